rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/rf_write_arbiter_if.sv | 40 ++++
 rtl/rf_wr_fifo.sv | 59 +++++
 rtl/rf_write_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: register-file widths and write-request type shared by the write arbiter.
// Revision: 1.0
`default_nettype none

package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_wr_req_t;

  // Register 0 is hardwired, so a buffered write to it never creates a hazard.
  function automatic logic addr_hits(input logic [REG_ADDR_W-1:0] a,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt);
    return (a != '0) && ((a == rs) || (a == rt));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback, long-latency, hazard and register-file port bundle.
// Revision: 1.0
`default_nettype none

interface rf_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
);
  logic                    wb_we_i;
  logic [REG_ADDR_W-1:0]   wb_addr_i;
  logic [REG_DATA_W-1:0]   wb_data_i;
  logic                    ll_valid_i;
  logic [REG_ADDR_W-1:0]   ll_addr_i;
  logic [REG_DATA_W-1:0]   ll_data_i;
  logic                    ll_ready_o;
  logic [REG_ADDR_W-1:0]   rs_addr_i;
  logic [REG_ADDR_W-1:0]   rt_addr_i;
  logic                    hazard_o;
  logic                    stall_o;
  logic                    RegWrite_o;
  logic [REG_ADDR_W-1:0]   RDaddr_o;
  logic [REG_DATA_W-1:0]   RDdata_o;
  logic [$clog2(FIFO_DEPTH):0] pending_o;

  modport master (
    output wb_we_i, wb_addr_i, wb_data_i, ll_valid_i, ll_addr_i, ll_data_i,
           rs_addr_i, rt_addr_i,
    input  ll_ready_o, hazard_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o, pending_o
  );

  modport slave (
    input  wb_we_i, wb_addr_i, wb_data_i, ll_valid_i, ll_addr_i, ll_data_i,
           rs_addr_i, rt_addr_i,
    output ll_ready_o, hazard_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o, pending_o
  );

endinterface

`default_nettype wire

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: circular buffer of long-latency writes; exposes every slot for hazard checks.
// Revision: 1.0
`default_nettype none

module rf_wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  rf_wr_req_t                push_entry,
  input  logic                      pop,
  output rf_wr_req_t                head,
  output rf_wr_req_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]          valid,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  rf_wr_req_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;

  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PTR_W-1:0] offset;
    assign offset   = PTR_W'(i) - rd_ptr;
    assign valid[i] = ({1'b0, offset} < count);
  end

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between writeback and a buffered
// long-latency unit. Optional starvation guard: RF_ARB_STARVE_GUARD_EN. Revision: 1.0
`default_nettype none

module rf_write_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  rf_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]            count;
  rf_wr_req_t                  head;
  rf_wr_req_t                  push_entry;
  rf_wr_req_t [FIFO_DEPTH-1:0] entries;
  logic [FIFO_DEPTH-1:0]       valid;
  logic                        nonempty;
  logic                        push;
  logic                        pop;
  logic                        wb_win;
  logic                        stall;
  logic                        win_any;
  rf_wr_req_t                  win_req;
  logic                        hit;

  assign nonempty        = (count != '0);
  assign bus.ll_ready_o  = (count < CNT_W'(FIFO_DEPTH)) && rst_i;
  assign push            = bus.ll_valid_i && bus.ll_ready_o;
  assign push_entry      = {bus.ll_addr_i, bus.ll_data_i};

  rf_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .valid      (valid),
    .count      (count)
  );

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  // Counts writeback wins while the head waits; at the limit writeback is held once.
  assign stall = rst_i && nonempty && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge clk_i) begin
    if (!rst_i || pop || !nonempty) starve_cnt <= '0;
    else if (wb_win)                starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign stall = 1'b0;
`endif

  assign wb_win = rst_i && bus.wb_we_i && !stall;
  assign pop    = rst_i && !wb_win && nonempty;

  always_comb begin
    win_any = 1'b0;
    win_req = '0;
    if (wb_win) begin
      win_any = 1'b1;
      win_req = {bus.wb_addr_i, bus.wb_data_i};
    end else if (pop) begin
      win_any = 1'b1;
      win_req = head;
    end
  end

  // A winner addressed to r0 is still consumed, it just never reaches the array.
  assign bus.RegWrite_o = win_any && (win_req.addr != '0);
  assign bus.RDaddr_o   = win_req.addr;
  assign bus.RDdata_o   = win_req.data;
  assign bus.stall_o    = stall;
  assign bus.pending_o  = count;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid[i] && addr_hits(entries[i].addr, bus.rs_addr_i, bus.rt_addr_i)) hit = 1'b1;
    end
  end

  assign bus.hazard_o = hit && rst_i;

endmodule

`default_nettype wire
